// File: rtl/sseg_scan_sched_if.sv
// sseg_scan_sched_if: banner-side inputs and display-pin outputs of the seven-segment scan scheduler.
interface sseg_scan_sched_if #(parameter int NUM_DIGITS = 8);
    logic                    en;
    logic [4*NUM_DIGITS-1:0] current_disp;
    logic [NUM_DIGITS-1:0]   digit_en;
    logic [3:0]              brightness;
    logic [NUM_DIGITS-1:0]   anode;
    logic [7:0]              cathodes;
    logic                    frame_tick;
    modport master (output en, current_disp, digit_en, brightness, input anode, cathodes, frame_tick);
    modport slave  (input en, current_disp, digit_en, brightness, output anode, cathodes, frame_tick);
endinterface

// File: rtl/sseg_scan_sched.sv
// sseg_scan_sched: time-multiplexed 8-digit seven-segment scan with per-slot dead time and brightness window.
// Define SSEG_LEADING_ZERO_BLANK_EN to blank leading zero digits at each frame start.
module sseg_scan_sched #(
    parameter int NUM_DIGITS   = 8,
    parameter int SLOT_CYCLES  = 12500,
    parameter int BLANK_CYCLES = 100
) (
    input  logic               clk,
    input  logic               rst_n,
    sseg_scan_sched_if.slave   bus
);
    localparam int ON_STEP = (SLOT_CYCLES - BLANK_CYCLES) / 16;
    localparam int CW = $clog2(SLOT_CYCLES);
    localparam int DW = $clog2(NUM_DIGITS);
    localparam logic [CW-1:0] SLOT_LAST = CW'(SLOT_CYCLES - 1);
    localparam logic [DW-1:0] DIG_LAST  = DW'(NUM_DIGITS - 1);
    localparam logic [CW:0]   BLANK_W   = (CW+1)'(BLANK_CYCLES);
    localparam logic [6:0] SEG [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    if (SLOT_CYCLES - BLANK_CYCLES < 16 || BLANK_CYCLES < 1) begin : g_bad_params
        $error("sseg_scan_sched: need SLOT_CYCLES-BLANK_CYCLES >= 16 and BLANK_CYCLES >= 1");
    end

    typedef enum logic {IDLE, SCAN} state_t;
    state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [DW-1:0] digit, digit_n;
    logic [4*NUM_DIGITS-1:0] disp_snap;
    logic [NUM_DIGITS-1:0] den_snap, keep;
    logic [3:0] b_snap;
    logic [CW:0] on_end;
    logic wrap, frame_start, drive;

`ifdef SSEG_LEADING_ZERO_BLANK_EN
    logic seen;
    // Walk from the top digit down; everything above the first non-zero nibble goes dark.
    always_comb begin
        seen = 1'b0;
        keep = '1;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            seen = seen | (bus.current_disp[4*i +: 4] != 4'h0);
            keep[i] = seen;
        end
    end
`else
    assign keep = '1;
`endif

    assign wrap        = cnt == SLOT_LAST;
    assign frame_start = state == SCAN && digit == '0 && cnt == '0;
    assign on_end      = BLANK_W + (CW+1)'((32'(b_snap) + 32'd1) * ON_STEP);
    assign drive       = bus.en && state == SCAN && den_snap[digit]
                         && {1'b0, cnt} >= BLANK_W && {1'b0, cnt} < on_end;

    always_comb begin
        state_n = state;
        cnt_n   = '0;
        digit_n = '0;
        if (state == IDLE) state_n = bus.en ? SCAN : IDLE;
        else if (!bus.en) state_n = IDLE;
        else begin
            cnt_n   = wrap ? '0 : cnt + 1'b1;
            digit_n = !wrap ? digit : (digit == DIG_LAST ? '0 : digit + 1'b1);
        end
    end

    // Outputs are registered from the current window, so pins trail slot_cnt by one cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            cnt            <= '0;
            digit          <= '0;
            disp_snap      <= '0;
            den_snap       <= '0;
            b_snap         <= '0;
            bus.anode      <= '1;
            bus.cathodes   <= '1;
            bus.frame_tick <= 1'b0;
        end else begin
            state          <= state_n;
            cnt            <= cnt_n;
            digit          <= digit_n;
            bus.frame_tick <= state_n == SCAN && digit_n == '0 && cnt_n == '0;
            bus.anode      <= drive ? ~(NUM_DIGITS'(1) << digit) : '1;
            bus.cathodes   <= drive ? ~{1'b0, SEG[disp_snap[{digit, 2'b00} +: 4]]} : '1;
            if (frame_start) begin
                disp_snap <= bus.current_disp;
                den_snap  <= bus.digit_en & keep;
                b_snap    <= bus.brightness;
            end
        end
    end
endmodule

// File: tb/tb_sseg_scan_sched.sv
// tb_sseg_scan_sched: directed checks of slot timing, snapshots, enables, en/reset drop and leading-zero option.
module tb_sseg_scan_sched;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_assert = 0;
    int n_fail = 0;
    int cur = 0;

    sseg_scan_sched_if #(.NUM_DIGITS(8)) sif ();
    sseg_scan_sched #(.NUM_DIGITS(8), .SLOT_CYCLES(40), .BLANK_CYCLES(8)) dut (
        .clk(clk), .rst_n(rst_n), .bus(sif)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic run_to(input int k);
        repeat (k - cur) @(negedge clk);
        cur = k;
    endtask

    // Cycle 0 is the negedge where frame_tick is first seen high.
    task automatic wait_tick(input string tag);
        int n = 0;
        while (sif.frame_tick !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk(tag, {31'd0, sif.frame_tick}, 32'd1);
        cur = 0;
    endtask

    task automatic pins(input string tag, input int k, input logic [7:0] an, input logic [7:0] ca);
        run_to(k);
        chk({tag, "_anode"}, {24'd0, sif.anode}, {24'd0, an});
        chk({tag, "_cath"}, {24'd0, sif.cathodes}, {24'd0, ca});
    endtask

    task automatic tick_at(input string tag, input int k, input logic v);
        run_to(k);
        chk(tag, {31'd0, sif.frame_tick}, {31'd0, v});
    endtask

    initial begin
        sif.en = 1'b0;
        sif.current_disp = 32'h87654321;
        sif.digit_en = 8'hFF;
        sif.brightness = 4'd15;
        repeat (3) @(negedge clk);
        chk("rst_anode", {24'd0, sif.anode}, 32'hFF);
        chk("rst_cath", {24'd0, sif.cathodes}, 32'hFF);
        chk("rst_tick", {31'd0, sif.frame_tick}, 32'd0);

        rst_n = 1'b1;
        sif.en = 1'b1;
        wait_tick("first_tick");
        tick_at("tick_one_cycle", 1, 1'b0);
        pins("blank_d0", 8, 8'hFF, 8'hFF);
        pins("d0_start", 9, 8'hFE, 8'hF9);
        pins("d0_end", 40, 8'hFE, 8'hF9);
        pins("gap_d1", 41, 8'hFF, 8'hFF);
        pins("gap_d1_end", 48, 8'hFF, 8'hFF);
        pins("d1_start", 49, 8'hFD, 8'hA4);
        pins("d1_end", 80, 8'hFD, 8'hA4);
        pins("d1_off", 81, 8'hFF, 8'hFF);
        pins("d7", 289, 8'h7F, 8'h80);
        run_to(300);
        sif.brightness = 4'd0;
        tick_at("tick_f2", 320, 1'b1);

        pins("b0_pre", 328, 8'hFF, 8'hFF);
        pins("b0_on0", 329, 8'hFE, 8'hF9);
        pins("b0_on1", 330, 8'hFE, 8'hF9);
        pins("b0_off", 331, 8'hFF, 8'hFF);
        pins("b0_d1", 369, 8'hFD, 8'hA4);
        pins("b0_d1_off", 371, 8'hFF, 8'hFF);
        run_to(400);
        sif.brightness = 4'd7;
        pins("b_mid_change", 411, 8'hFF, 8'hFF);
        tick_at("tick_f3", 640, 1'b1);
        pins("b7_last", 664, 8'hFE, 8'hF9);
        pins("b7_off", 665, 8'hFF, 8'hFF);

        run_to(900);
        sif.digit_en = 8'h0F;
        tick_at("tick_f4", 960, 1'b1);
        pins("den_d0", 969, 8'hFE, 8'hF9);
        pins("den_d3", 1089, 8'hF7, 8'h99);
        pins("den_d4", 1129, 8'hFF, 8'hFF);
        pins("den_d7", 1249, 8'hFF, 8'hFF);
        run_to(1250);
        sif.digit_en = 8'hFF;
        sif.current_disp = 32'h11111111;
        tick_at("tick_f5", 1280, 1'b1);

        pins("disp1_d0", 1289, 8'hFE, 8'hF9);
        run_to(1400);
        sif.current_disp = 32'hFFFFFFFF;
        pins("disp_no_tear", 1489, 8'hDF, 8'hF9);
        tick_at("tick_f6", 1600, 1'b1);
        pins("dispF_d0", 1609, 8'hFE, 8'h8E);

        pins("en_d3_drive", 1730, 8'hF7, 8'h8E);
        sif.en = 1'b0;
        pins("en_drop", 1731, 8'hFF, 8'hFF);
        pins("en_idle", 1733, 8'hFF, 8'hFF);
        tick_at("en_idle_tick", 1734, 1'b0);
        run_to(1735);
        sif.en = 1'b1;
        wait_tick("reen_tick");
        pins("reen_blank", 8, 8'hFF, 8'hFF);
        pins("reen_d0", 9, 8'hFE, 8'h8E);
        pins("pre_rst_d1", 49, 8'hFD, 8'h8E);
        run_to(50);
        rst_n = 1'b0;
        pins("mid_rst", 51, 8'hFF, 8'hFF);
        tick_at("mid_rst_tick", 55, 1'b0);
        rst_n = 1'b1;
        wait_tick("post_rst_tick");
        pins("post_rst_d0", 9, 8'hFE, 8'h8E);

        run_to(300);
        sif.current_disp = 32'h00000450;
        tick_at("tick_lz1", 320, 1'b1);
        pins("lz_d0", 329, 8'hFE, 8'hC0);
        pins("lz_d2", 409, 8'hFB, 8'h99);
`ifdef SSEG_LEADING_ZERO_BLANK_EN
        pins("lz_d3_dark", 449, 8'hFF, 8'hFF);
`else
        pins("lz_d3_zero", 449, 8'hF7, 8'hC0);
`endif
        run_to(600);
        sif.current_disp = 32'h00000000;
        tick_at("tick_lz2", 640, 1'b1);
        pins("zero_d0", 649, 8'hFE, 8'hC0);
`ifdef SSEG_LEADING_ZERO_BLANK_EN
        pins("zero_d1_dark", 689, 8'hFF, 8'hFF);
`else
        pins("zero_d1", 689, 8'hFD, 8'hC0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/sseg_scan_sched.md
Name: sseg_scan_sched

Overview:
Time-multiplexing scheduler that shares the single 8-bit cathode bus of the 8-digit seven-segment display among the eight anodes. It takes the 32-bit digit word from the banner controller, snapshots it once per frame, and drives one digit per time slot. Each slot starts with a dead-time blanking interval to prevent ghosting and ends with a brightness-scaled drive window. It sits between the banner controller and the board pins, on the 100 MHz system clock.

Parameters:
NUM_DIGITS, 8, number of multiplexed digits; digit i occupies bits [4i+3:4i] of current_disp.
SLOT_CYCLES, 12500, clk cycles per digit slot (8 kHz slot rate, 1 kHz frame rate at 100 MHz).
BLANK_CYCLES, 100, dead-time cycles at the start of each slot with all anodes off.
ON_STEP, (SLOT_CYCLES-BLANK_CYCLES)/16, localparam; drive cycles per brightness step.

Ports:
clk  input  1  system clock, 100 MHz
rst_n  input  1  synchronous reset, active-low
en  input  1  scan enable; low forces display dark
current_disp  input  4*NUM_DIGITS  hex nibbles; nibble 0 is the rightmost digit
digit_en  input  NUM_DIGITS  per-digit enable; a 0 keeps that anode off during its slot
brightness  input  4  level b, 0..15; drive window is (b+1)*ON_STEP cycles
anode  output  NUM_DIGITS  active-low digit selects; anode[i] drives digit i
cathodes  output  8  active-low segments {dp,g,f,e,d,c,b,a}; dp is always 1 (off)
frame_tick  output  1  one-cycle pulse on the first cycle of every frame

Behaviour:
- Clock and reset: single clock domain, clk. rst_n is synchronous and active-low.
- Reset values (rst_n low at an edge): anode=all 1s, cathodes=8'hFF, frame_tick=0, state=IDLE, digit index=0, slot_cnt=0, snapshots cleared.
- FSM states:
  - IDLE: outputs dark. Moves to SCAN on the edge where en=1, with slot_cnt=0 and digit=0.
  - SCAN: slot_cnt counts 0..SLOT_CYCLES-1.
    - At wrap, digit increments.
    - At digit NUM_DIGITS-1 wrap, digit returns to 0 and a new frame starts.
- Frame start: the cycle with digit=0 and slot_cnt=0.
  - current_disp, digit_en and brightness are snapshotted together; the displayed data cannot tear within a frame.
  - frame_tick=1 for that cycle only.
  - ON_CYCLES=(b_snap+1)*ON_STEP.
- Per slot, the internal window is decided by slot_cnt:
  - blank while slot_cnt < BLANK_CYCLES;
  - drive while BLANK_CYCLES <= slot_cnt < BLANK_CYCLES+ON_CYCLES;
  - blank for the remainder.
- Outputs are registered, so they lag the internal window by 1 cycle. With the frame_tick cycle numbered 0, anode[i] is low exactly on cycles i*SLOT_CYCLES+BLANK_CYCLES+1 through i*SLOT_CYCLES+BLANK_CYCLES+ON_CYCLES, provided digit_en_snap[i]=1.
- At most one anode bit is low at any cycle.
- Cathodes carry the hex decode of the current nibble during drive and 8'hFF otherwise. Active-high a..g patterns:
  - 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07
  - 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71
  - Driven value = ~{1'b0,pattern[6:0]}.
- Disabled digits (digit_en_snap[i]=0) keep their full slot time with anode and cathodes dark. Frame rate is therefore constant.
- en low sampled in SCAN: the next state is IDLE and outputs are dark from the following cycle; no slot completion. Re-enable always starts a fresh frame at digit 0 with a full blank interval.
- rst_n low mid-frame overrides en and returns all registers to their reset values on that edge.
- Inputs that change mid-frame have no effect until the next frame start.
- Elaboration checks: SLOT_CYCLES-BLANK_CYCLES >= 16 and BLANK_CYCLES >= 1; violation is an elaboration $error.
- Counter widths: $clog2(SLOT_CYCLES) and $clog2(NUM_DIGITS).

Optional Feature:
SSEG_LEADING_ZERO_BLANK_EN
- Defined: at frame start, leading zero nibbles are forced dark from the most significant digit downward until the first non-zero nibble. The cleared enables are ANDed into the digit_en snapshot. Digit 0 is never blanked, so all-zero input shows a single "0".
- Undefined: every enabled digit is shown, including leading zeros; no extra logic.

Test Plan:
- Bench parameters: SLOT_CYCLES=40, BLANK_CYCLES=8, so ON_STEP=2.
- Reset, then en=1, current_disp=32'h87654321, digit_en=8'hFF, brightness=15 -> frame_tick on cycle 0; anode=8'hFE with cathodes=~8'h06 on cycles 9..40; anode=8'hFD with cathodes=~8'h5B on cycles 49..80; all dark on cycles 1..8 and 41..48; next frame_tick on cycle 320.
- brightness=0 -> each anode low for exactly 2 cycles per slot (e.g., digit 0 on cycles 9..10); brightness changed to 7 mid-frame -> no effect until the next frame_tick, then 16 cycles per slot.
- digit_en=8'h0F -> digits 4..7 never drive an anode low; frame period stays 320 cycles; digits 0..3 timing is unchanged.
- current_disp changed from 32'h11111111 to 32'hFFFFFFFF mid-frame -> the remainder of the frame still shows ~8'h06; ~8'h71 appears from the next frame.
- en dropped during digit 3's drive window -> anode=8'hFF and cathodes=8'hFF from the next cycle; en re-raised -> frame_tick, digit 0, 8-cycle blank first. rst_n low mid-frame -> all reset values on the next edge.
- With SSEG_LEADING_ZERO_BLANK_EN defined: current_disp=32'h00000450 -> only digits 0..2 are driven; 32'h00000000 -> only digit 0 is driven, showing ~8'h3F.
